// File: rtl/key_event_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module   : key_event_ctrl_pkg
// Brief    : Shared event codes, per-key FSM encoding and width helper for
//            the multi-key event controller.
// Revision : 1.0 - initial release
//============================================================================
package key_event_ctrl_pkg;

  // Event codes carried in the FIFO alongside the key index
  localparam logic [1:0] c_EVT_SHORT = 2'b01;
  localparam logic [1:0] c_EVT_LONG  = 2'b10;

  // Per-key press classifier states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_HELD = 2'd2
  } key_fsm_e;

  // Key index width; a single-key build still needs a 1-bit index field
  function automatic int key_idx_w(input int num_keys);
    return (num_keys > 1) ? $clog2(num_keys) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_ctrl_if.sv
`default_nettype none
//============================================================================
// Module   : key_event_ctrl_if
// Brief    : Show-ahead valid/ready pop port of the key event FIFO.
//            master = event source (controller), slave = CPU side.
// Revision : 1.0 - initial release
//============================================================================
interface key_event_ctrl_if #(
  parameter int KEY_W = 2
);
  logic             evt_valid;
  logic [KEY_W-1:0] evt_key;
  logic [1:0]       evt_code;
  logic             evt_ready;

  modport master (
    output evt_valid,
    output evt_key,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_key,
    input  evt_code,
    output evt_ready
  );
endinterface
`default_nettype wire

// File: rtl/key_event_ctrl_debounce.sv
`default_nettype none
//============================================================================
// Module   : key_event_ctrl_debounce
// Brief    : One key: 2-FF synchroniser, sample history debounce, and the
//            SHORT/LONG press classifier with its hold counter.
// Revision : 1.0 - initial release
//============================================================================
module key_event_ctrl_debounce
  import key_event_ctrl_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4,
  parameter int LONG_TICKS     = 100
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic key_n,
  input  wire logic tick,
  output logic      level,
  output logic      raise_short,
  output logic      raise_long
);

  localparam int                 c_CNT_W    = $clog2(LONG_TICKS);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LONG_TICKS - 1);

  logic                      r_sync1;
  logic                      r_sync2;
  logic [STABLE_SAMPLES-1:0] r_hist;
  logic [STABLE_SAMPLES-1:0] w_hist_nxt;
  logic                      r_level;
  logic                      w_level_nxt;
  key_fsm_e                  r_state;
  key_fsm_e                  w_state_nxt;
  logic [c_CNT_W-1:0]        r_cnt;
  logic [c_CNT_W-1:0]        w_cnt_nxt;

  // Bring the asynchronous button into the clock domain; idle level is released
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_hist_nxt = {r_hist[STABLE_SAMPLES-2:0], r_sync2};

  // Debounced level follows only a fully uniform history, otherwise holds
  always_comb begin
    w_level_nxt = r_level;
    if (w_hist_nxt == '0) begin
      w_level_nxt = 1'b1;
    end else if (&w_hist_nxt) begin
      w_level_nxt = 1'b0;
    end
  end

  // Sample history and debounced level advance on the sample tick only
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist  <= '1;
      r_level <= 1'b0;
    end else if (tick) begin
      r_hist  <= w_hist_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Classifier state and hold counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Classifier sees the level being latched this tick, so a press is
  // recognised in the same tick the debounce accepts it
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    raise_short = 1'b0;
    raise_long  = 1'b0;
    if (tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_level_nxt) begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
          end
        end
        ST_HELD: begin
          if (!w_level_nxt) begin
            raise_short = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (r_cnt == c_CNT_LAST) begin
            raise_long  = 1'b1;
            w_state_nxt = ST_LONG_HELD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (!w_level_nxt) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
//============================================================================
// Module   : key_event_ctrl
// Brief    : Multi-key front end: sample prescaler, per-key debounce and
//            press classification, pending-event arbiter and show-ahead
//            event FIFO drained by the CPU. evt_valid is the IRQ line.
// Revision : 1.0 - initial release
//============================================================================
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int SAMPLE_DIV     = 500000,
  parameter int STABLE_SAMPLES = 4,
  parameter int LONG_TICKS     = 100,
  parameter int FIFO_DEPTH     = 4
) (
  input  wire logic                clk,
  input  wire logic                rstn,
  input  wire logic [NUM_KEYS-1:0] key_n,
  key_event_ctrl_if.master         evt,
  output logic      [NUM_KEYS-1:0] key_state,
  output logic                     evt_ovf,
  input  wire logic                ovf_clr
);

  localparam int                 c_KEY_W   = key_idx_w(NUM_KEYS);
  localparam int                 c_PS_W    = $clog2(SAMPLE_DIV);
  localparam logic [c_PS_W-1:0]  c_PS_LAST = c_PS_W'(SAMPLE_DIV - 1);
  localparam int                 c_AW      = $clog2(FIFO_DEPTH);

  logic [c_PS_W-1:0]   r_ps;
  logic                w_tick;

  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_raise_short;
  logic [NUM_KEYS-1:0] w_raise_long;

  logic [NUM_KEYS-1:0] r_pend;
  logic [1:0]          r_pend_code [NUM_KEYS];

  logic                w_grant_vld;
  logic [c_KEY_W-1:0]  w_grant_idx;
  logic [1:0]          w_grant_code;

  logic [c_KEY_W-1:0]  r_mem_key  [FIFO_DEPTH];
  logic [1:0]          r_mem_code [FIFO_DEPTH];
  logic [c_AW:0]       r_wr_ptr;
  logic [c_AW:0]       r_rd_ptr;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                r_ovf;

  // Free-running sample prescaler; wraps at SAMPLE_DIV-1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ps <= '0;
    end else if (r_ps == c_PS_LAST) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + 1'b1;
    end
  end

  assign w_tick = (r_ps == c_PS_LAST);

  generate
    for (genvar gk = 0; gk < NUM_KEYS; gk++) begin : g_key
      key_event_ctrl_debounce #(
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .LONG_TICKS     (LONG_TICKS)
      ) u_debounce (
        .clk         (clk),
        .rstn        (rstn),
        .key_n       (key_n[gk]),
        .tick        (w_tick),
        .level       (w_level[gk]),
        .raise_short (w_raise_short[gk]),
        .raise_long  (w_raise_long[gk])
      );
    end
  endgenerate

  assign key_state = w_level;

  // Lowest-index pending key wins the single push slot this cycle
  always_comb begin
    w_grant_vld  = 1'b0;
    w_grant_idx  = '0;
    w_grant_code = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (r_pend[k]) begin
        w_grant_vld  = 1'b1;
        w_grant_idx  = c_KEY_W'(k);
        w_grant_code = r_pend_code[k];
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop   = !w_empty && evt.evt_ready;
  // A pop frees the head slot in the same cycle, so full+pop still accepts
  assign w_push  = w_grant_vld && (!w_full || w_pop);
  assign w_drop  = w_grant_vld && w_full && !w_pop;

  // One pending slot per key; a raise always lands, a grant retires it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_pend_code[k] <= 2'b00;
      end
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (w_raise_short[k] || w_raise_long[k]) begin
          r_pend[k]      <= 1'b1;
          r_pend_code[k] <= w_raise_long[k] ? c_EVT_LONG : c_EVT_SHORT;
        end else if (w_grant_vld && (w_grant_idx == c_KEY_W'(k))) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_key[r_wr_ptr[c_AW-1:0]]  <= w_grant_idx;
      r_mem_code[r_wr_ptr[c_AW-1:0]] <= w_grant_code;
    end
  end

  // FIFO pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign evt_ovf       = r_ovf;
  assign evt.evt_valid = !w_empty;
  assign evt.evt_key   = w_empty ? '0 : r_mem_key[r_rd_ptr[c_AW-1:0]];
  assign evt.evt_code  = w_empty ? '0 : r_mem_code[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_key_event_ctrl
// Brief    : Self-checking bench for key_event_ctrl with a scoreboard of
//            expected {key, code} entries popped as the CPU side drains.
// Revision : 1.0 - initial release
//============================================================================
module tb_key_event_ctrl;

  localparam int NUM_KEYS       = 4;
  localparam int SAMPLE_DIV     = 8;
  localparam int STABLE_SAMPLES = 3;
  localparam int LONG_TICKS     = 5;
  localparam int FIFO_DEPTH     = 4;
  localparam int KEY_W          = 2;

  localparam logic [1:0] SHORT = 2'b01;
  localparam logic [1:0] LONG  = 2'b10;

  logic                clk     = 1'b0;
  logic                rstn    = 1'b0;
  logic [NUM_KEYS-1:0] key_n   = '1;
  logic [NUM_KEYS-1:0] key_state;
  logic                evt_ovf;
  logic                ovf_clr = 1'b0;

  key_event_ctrl_if #(.KEY_W(KEY_W)) evt_if ();

  key_event_ctrl #(
    .NUM_KEYS       (NUM_KEYS),
    .SAMPLE_DIV     (SAMPLE_DIV),
    .STABLE_SAMPLES (STABLE_SAMPLES),
    .LONG_TICKS     (LONG_TICKS),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .key_n     (key_n),
    .evt       (evt_if.master),
    .key_state (key_state),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_cyc;
  int          last_tick = -100;
  logic        prev_valid = 1'b0;
  logic [3:0]  sb [$];
  int          pop_cyc [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Cycles since reset release; the sample tick lands where n_cyc % 8 == 7
  always @(posedge clk or negedge rstn) begin
    if (!rstn) n_cyc <= 0;
    else       n_cyc <= n_cyc + 1;
  end

  // CPU-side monitor: latency of each new head and in-order pops
  always @(negedge clk) begin
    #2;
    if (rstn) begin
      if (evt_if.evt_valid && !prev_valid)
        check_val("latency", n_cyc - last_tick, 2);
      if (n_cyc % 8 == 7) last_tick = n_cyc;
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        if (sb.size() == 0) begin
          check_val("spurious_evt", evt_if.evt_valid, 0);
        end else begin
          check_val("evt_entry", {evt_if.evt_key, evt_if.evt_code}, sb.pop_front());
          pop_cyc.push_back(n_cyc);
        end
      end
      prev_valid = evt_if.evt_valid;
    end else begin
      prev_valid = 1'b0;
      last_tick  = -100;
    end
  end

  task automatic align();
    do @(negedge clk); while (n_cyc % 8 != 0);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(negedge clk); while (n_cyc % 8 != 7);
    end
  endtask

  // Four zero samples then release: debounced press lasts well under LONG
  task automatic press_short(input int k);
    align();
    key_n[k] = 1'b0;
    wait_ticks(4);
    key_n[k] = 1'b1;
    wait_ticks(5);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int keys5 [6] = '{0, 1, 2, 3, 0, 1};
    evt_if.evt_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_valid", evt_if.evt_valid, 0);
    check_val("rst_key",   evt_if.evt_key, 0);
    check_val("rst_code",  evt_if.evt_code, 0);
    check_val("rst_state", key_state, 0);
    check_val("rst_ovf",   evt_ovf, 0);
    rstn = 1'b1;

    // 1: short press on key 1, level after exactly 3 zero samples
    align();
    key_n[1] = 1'b0;
    wait_ticks(3);
    check_val("t1_state_early", key_state[1], 0);
    @(negedge clk);
    check_val("t1_state_rise", key_state[1], 1);
    wait_ticks(1);
    sb.push_back({2'd1, SHORT});
    key_n[1] = 1'b1;
    wait_ticks(6);
    check_val("t1_drained", sb.size(), 0);
    check_val("t1_state_fall", key_state[1], 0);

    // 2: long hold on key 2, one LONG and nothing on release
    align();
    sb.push_back({2'd2, LONG});
    key_n[2] = 1'b0;
    wait_ticks(12);
    check_val("t2_state_held", key_state[2], 1);
    key_n[2] = 1'b1;
    wait_ticks(6);
    check_val("t2_drained", sb.size(), 0);
    check_val("t2_state_fall", key_state[2], 0);

    // 3: bounce on key 0. A 3-clk toggle never yields three equal samples
    // at an 8-clk sample period (a 5-clk toggle aliases into runs of three)
    for (int i = 0; i < 34; i++) begin
      key_n[0] = ~key_n[0];
      repeat (3) @(negedge clk);
      check_val("t3_bounce_state", key_state[0], 0);
    end
    wait_ticks(4);
    check_val("t3_state", key_state[0], 0);
    check_val("t3_empty", evt_if.evt_valid, 0);

    // 4: keys 0 and 3 released on the same tick -> 0 then 3, back to back
    align();
    key_n[0] = 1'b0;
    key_n[3] = 1'b0;
    wait_ticks(4);
    pop_cyc.delete();
    sb.push_back({2'd0, SHORT});
    sb.push_back({2'd3, SHORT});
    key_n[0] = 1'b1;
    key_n[3] = 1'b1;
    wait_ticks(5);
    check_val("t4_drained", sb.size(), 0);
    check_val("t4_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2)
      check_val("t4_consecutive", pop_cyc[1] - pop_cyc[0], 1);

    // 5: overflow with the CPU stalled
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) sb.push_back({2'(keys5[i]), SHORT});
      press_short(keys5[i]);
      if (i == 3) begin
        check_val("t5_ovf_at_full", evt_ovf, 0);
        check_val("t5_valid_full", evt_if.evt_valid, 1);
      end
      if (i == 4) check_val("t5_ovf_set", evt_ovf, 1);
    end
    check_val("t5_head_stable", {evt_if.evt_key, evt_if.evt_code}, {2'd0, SHORT});
    evt_if.evt_ready = 1'b1;
    repeat (8) @(negedge clk);
    check_val("t5_drained", sb.size(), 0);
    check_val("t5_empty", evt_if.evt_valid, 0);
    check_val("t5_ovf_sticky", evt_ovf, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    @(negedge clk);
    check_val("t5_ovf_clr", evt_ovf, 0);

    // 6: reset mid-hold with two entries queued
    evt_if.evt_ready = 1'b0;
    press_short(0);
    press_short(1);
    check_val("t6_queued", evt_if.evt_valid, 1);
    align();
    key_n[2] = 1'b0;
    wait_ticks(4);
    check_val("t6_held", key_state[2], 1);
    rstn = 1'b0;
    #1;
    check_val("t6_rst_valid", evt_if.evt_valid, 0);
    check_val("t6_rst_state", key_state, 0);
    key_n = '1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    evt_if.evt_ready = 1'b1;
    wait_ticks(10);
    check_val("t6_no_stale", evt_if.evt_valid, 0);
    check_val("t6_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
